// File: rtl/csr_bus_arbiter_if.sv
// Both requester ports and the register-map port of the two-way CSR arbiter.
// slave is the arbiter's view of the bundle; master is the surrounding logic's view.
interface csr_bus_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic                  m0_req;
  logic                  m0_req_is_wr;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wr_data;
  logic [DATA_WIDTH-1:0] m0_wr_biten;
  logic                  m0_ready;
  logic                  m0_err;
  logic [DATA_WIDTH-1:0] m0_rd_data;

  logic                  m1_req;
  logic                  m1_req_is_wr;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wr_data;
  logic [DATA_WIDTH-1:0] m1_wr_biten;
  logic                  m1_ready;
  logic                  m1_err;
  logic [DATA_WIDTH-1:0] m1_rd_data;

  logic                  bus_req;
  logic                  bus_req_is_wr;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wr_data;
  logic [DATA_WIDTH-1:0] bus_wr_biten;
  logic                  bus_ready;
  logic                  bus_err;
  logic [DATA_WIDTH-1:0] bus_rd_data;

  modport slave (
    input  m0_req, m0_req_is_wr, m0_addr, m0_wr_data, m0_wr_biten,
    output m0_ready, m0_err, m0_rd_data,
    input  m1_req, m1_req_is_wr, m1_addr, m1_wr_data, m1_wr_biten,
    output m1_ready, m1_err, m1_rd_data,
    output bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
    input  bus_ready, bus_err, bus_rd_data
  );

  modport master (
    output m0_req, m0_req_is_wr, m0_addr, m0_wr_data, m0_wr_biten,
    input  m0_ready, m0_err, m0_rd_data,
    output m1_req, m1_req_is_wr, m1_addr, m1_wr_data, m1_wr_biten,
    input  m1_ready, m1_err, m1_rd_data,
    input  bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
    output bus_ready, bus_err, bus_rd_data
  );
endinterface

// File: rtl/csr_bus_arbiter.sv
// Round-robin arbiter letting two requesters share one CSR register-map port,
// one transaction at a time, with a response timeout.
module csr_bus_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              reset,
  csr_bus_arbiter_if.slave io
);
  // state | meaning
  // IDLE  | waiting for a request; picks a winner and latches its fields
  // ISSUE | one-cycle bus_req pulse; bus_ready already honoured here
  // WAIT  | waiting for bus_ready or the timeout
  // RESP  | one-cycle ready pulse to the granted requester
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  bus_wr_q, bus_wr_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_WIDTH-1:0] bus_biten_q, bus_biten_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  any_req;
  logic                  win;
  logic                  timeout;
  logic                  rsp_m0, rsp_m1;

  assign any_req = io.m0_req | io.m1_req;
  assign cnt_inc = cnt_q + 1'b1;
  assign timeout = (cnt_inc == CNT_LIMIT);

  // On a tie the requester not granted last time wins
  always_comb begin
    if (io.m0_req && io.m1_req) win = ~last_q;
    else                        win = io.m1_req;
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (any_req) state_d = ISSUE;
      ISSUE, WAIT: begin
        if (io.bus_ready || timeout) state_d = RESP;
        else                         state_d = WAIT;
      end
      RESP:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    bus_wr_d    = bus_wr_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_biten_d = bus_biten_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d     = win;
          cnt_d       = '0;
          bus_wr_d    = win ? io.m1_req_is_wr : io.m0_req_is_wr;
          bus_addr_d  = win ? io.m1_addr      : io.m0_addr;
          bus_wdata_d = win ? io.m1_wr_data   : io.m0_wr_data;
          bus_biten_d = win ? io.m1_wr_biten  : io.m0_wr_biten;
        end
      end
      ISSUE, WAIT: begin
        cnt_d = cnt_inc;
        // A real response in the final counted cycle beats the timeout
        if (io.bus_ready) begin
          rsp_err_d  = io.bus_err;
          rsp_data_d = io.bus_rd_data;
        end else if (timeout) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end
      end
      RESP:    last_d = grant_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_biten_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_biten_q <= bus_biten_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    rsp_m0        = (state_q == RESP) && !grant_q;
    rsp_m1        = (state_q == RESP) &&  grant_q;
    io.bus_req    = (state_q == ISSUE);
    io.m0_ready   = rsp_m0;
    io.m1_ready   = rsp_m1;
    io.m0_err     = rsp_m0 & rsp_err_q;
    io.m1_err     = rsp_m1 & rsp_err_q;
    io.m0_rd_data = rsp_m0 ? rsp_data_q : '0;
    io.m1_rd_data = rsp_m1 ? rsp_data_q : '0;
  end

  assign io.bus_req_is_wr = bus_wr_q;
  assign io.bus_addr      = bus_addr_q;
  assign io.bus_wr_data   = bus_wdata_q;
  assign io.bus_wr_biten  = bus_biten_q;

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Bench for csr_bus_arbiter: directed vector table, reset/late-response
// sequences, then random transactions against a transaction-level model.
module tb_csr_bus_arbiter;
  localparam int T = 8;

  typedef struct {
    logic        r0, r1;
    logic        wr0, wr1;
    logic [10:0] a0, a1;
    logic [31:0] wd0, wd1;
    logic [31:0] be0, be1;
    int          dly;
    logic        berr;
    logic [31:0] brd;
    logic        exp_win;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic model_last;
  vec_t tbl[11];
  vec_t rv;

  always #5 clk = ~clk;

  csr_bus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) bif ();

  csr_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .TIMEOUT_CYCLES(T)) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bif)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic er0, input logic er1,
                          input logic eerr, input logic [31:0] erd, input logic ebreq);
    chk({tag, ".m0_ready"}, bif.m0_ready, er0);
    chk({tag, ".m1_ready"}, bif.m1_ready, er1);
    chk({tag, ".m0_err"}, bif.m0_err, er0 & eerr);
    chk({tag, ".m1_err"}, bif.m1_err, er1 & eerr);
    chk({tag, ".m0_rd_data"}, bif.m0_rd_data, er0 ? erd : 32'h0);
    chk({tag, ".m1_rd_data"}, bif.m1_rd_data, er1 ? erd : 32'h0);
    chk({tag, ".bus_req"}, bif.bus_req, ebreq);
  endtask

  task automatic chk_bus(input string tag, input logic wr, input logic [10:0] a,
                         input logic [31:0] wd, input logic [31:0] be);
    chk({tag, ".bus_req_is_wr"}, bif.bus_req_is_wr, wr);
    chk({tag, ".bus_addr"}, bif.bus_addr, a);
    chk({tag, ".bus_wr_data"}, bif.bus_wr_data, wd);
    chk({tag, ".bus_wr_biten"}, bif.bus_wr_biten, be);
  endtask

  task automatic drive_reqs(input vec_t v);
    bif.m0_req = v.r0;  bif.m0_req_is_wr = v.wr0; bif.m0_addr = v.a0;
    bif.m0_wr_data = v.wd0; bif.m0_wr_biten = v.be0;
    bif.m1_req = v.r1;  bif.m1_req_is_wr = v.wr1; bif.m1_addr = v.a1;
    bif.m1_wr_data = v.wd1; bif.m1_wr_biten = v.be1;
  endtask

  // Called during an IDLE cycle, before the edge that samples the requests.
  task automatic txn(input vec_t v, input string tag, input bit jitter);
    logic        ewr;
    logic [10:0] ea;
    logic [31:0] ewd, ebe;
    logic        rdy;
    ewr = v.exp_win ? v.wr1 : v.wr0;
    ea  = v.exp_win ? v.a1  : v.a0;
    ewd = v.exp_win ? v.wd1 : v.wd0;
    ebe = v.exp_win ? v.be1 : v.be0;
    drive_reqs(v);
    for (int c = 1; c <= 1 + v.exp_lat; c++) begin
      @(posedge clk); #1;
      bif.bus_ready = (c == 1 + v.dly);
      if (bif.bus_ready) begin
        bif.bus_err = v.berr;
        bif.bus_rd_data = v.brd;
      end else begin
        bif.bus_err = 1'($urandom);
        bif.bus_rd_data = $urandom;
      end
      if (jitter) begin
        bif.m0_addr = 11'($urandom); bif.m0_wr_data = $urandom; bif.m0_wr_biten = $urandom;
        bif.m1_addr = 11'($urandom); bif.m1_wr_data = $urandom; bif.m1_wr_biten = $urandom;
        bif.m0_req_is_wr = 1'($urandom); bif.m1_req_is_wr = 1'($urandom);
        if (v.exp_win) bif.m0_req = 1'($urandom);
        else           bif.m1_req = 1'($urandom);
      end
      @(negedge clk);
      rdy = (c == 1 + v.exp_lat);
      chk_outs(tag, rdy && !v.exp_win, rdy && v.exp_win, v.exp_err, v.exp_rd, c == 1);
      chk_bus(tag, ewr, ea, ewd, ebe);
    end
    @(posedge clk); #1;
    bif.bus_ready = 1'b0;
    @(negedge clk);
    chk_outs({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    model_last = v.exp_win;
  endtask

  // Transaction-level expectations from the arbitration and timeout rules.
  function automatic vec_t model(input vec_t v);
    vec_t m = v;
    if (v.r0 && v.r1) m.exp_win = ~model_last;
    else              m.exp_win = v.r1;
    if (v.dly < T) begin
      m.exp_lat = v.dly + 1;
      m.exp_err = v.berr;
      m.exp_rd  = v.brd;
    end else begin
      m.exp_lat = T;
      m.exp_err = 1'b1;
      m.exp_rd  = 32'h0;
    end
    return m;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 11'h100, 11'h200, 32'h0, 32'hCAFE0001, 32'h0, 32'hFFFFFFFF,
                0, 1'b0, 32'h11110000, 1'b0, 1, 1'b0, 32'h11110000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 11'h100, 11'h200, 32'h0, 32'hCAFE0001, 32'h0, 32'hFFFFFFFF,
                1, 1'b0, 32'h22220000, 1'b1, 2, 1'b0, 32'h22220000};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 11'h100, 11'h200, 32'h0, 32'hCAFE0001, 32'h0, 32'hFFFFFFFF,
                0, 1'b1, 32'h33330000, 1'b0, 1, 1'b1, 32'h33330000};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 11'h100, 11'h200, 32'h0, 32'hCAFE0001, 32'h0, 32'hFFFFFFFF,
                2, 1'b0, 32'h44440000, 1'b1, 3, 1'b0, 32'h44440000};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 11'h010, 11'h000, 32'h0, 32'h0, 32'h0, 32'h0,
                0, 1'b0, 32'hDEADBEEF, 1'b0, 1, 1'b0, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 11'h000, 11'h7FC, 32'h0, 32'h12345678, 32'h0, 32'h0000FFFF,
                0, 1'b1, 32'hA5A5A5A5, 1'b1, 1, 1'b1, 32'hA5A5A5A5};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 11'h3F0, 11'h000, 32'h0BADF00D, 32'h0, 32'hFF00FF00, 32'h0,
                5, 1'b0, 32'h55550000, 1'b0, 6, 1'b0, 32'h55550000};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h123, 32'h0, 32'h0, 32'h0, 32'h0,
                7, 1'b0, 32'h77770000, 1'b1, 8, 1'b0, 32'h77770000};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 11'h044, 11'h000, 32'h0, 32'h0, 32'h0, 32'h0,
                8, 1'b0, 32'hFFFFFFFF, 1'b0, 8, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 11'h066, 11'h077, 32'h66, 32'h77, 32'hF, 32'hF0,
                3, 1'b0, 32'h0A0A0A0A, 1'b1, 4, 1'b0, 32'h0A0A0A0A};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 11'h000, 11'h055, 32'h0, 32'h9, 32'h0, 32'h1,
                30, 1'b0, 32'h0, 1'b1, 8, 1'b1, 32'h0};

    reset = 1'b0;
    rv = '{1'b0, 1'b0, 1'b0, 1'b0, 11'h0, 11'h0, 32'h0, 32'h0, 32'h0, 32'h0,
           0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 32'h0};
    drive_reqs(rv);
    bif.bus_ready = 1'b0; bif.bus_err = 1'b0; bif.bus_rd_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_bus("reset", 1'b0, 11'h0, 32'h0, 32'h0);
    reset = 1'b1;
    model_last = 1'b1;

    for (int i = 0; i < 11; i++) txn(tbl[i], $sformatf("vec%0d", i), 1'b0);

    // Response arriving after the timeout has already been reported
    rv.r0 = 1'b0; rv.r1 = 1'b0;
    drive_reqs(rv);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bif.bus_ready = 1'b1; bif.bus_err = 1'b1; bif.bus_rd_data = $urandom;
      @(negedge clk);
      chk_outs("late_ready", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    end
    bif.bus_ready = 1'b0;

    // Reset while waiting on the register map, then the held request is served
    rv = '{1'b0, 1'b1, 1'b0, 1'b1, 11'h0, 11'h2A5, 32'h0, 32'hC0FFEE00, 32'h0, 32'hFFFF0000,
           2, 1'b0, 32'hBEEF0001, 1'b1, 3, 1'b0, 32'hBEEF0001};
    drive_reqs(rv);
    @(posedge clk); #1;
    @(negedge clk);
    chk_outs("rst_issue", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_bus("rst_issue", 1'b1, 11'h2A5, 32'hC0FFEE00, 32'hFFFF0000);
    @(posedge clk); #1;
    @(negedge clk);
    chk_outs("rst_wait", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_outs("rst_wait2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk_outs("rst_clear", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_bus("rst_clear", 1'b0, 11'h0, 32'h0, 32'h0);
    model_last = 1'b1;
    txn(rv, "rst_served", 1'b0);

    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        bif.m0_req = 1'b0; bif.m1_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_outs($sformatf("rnd%0d.noreq", i), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      end else begin
        rv.r0 = sel[0]; rv.r1 = sel[1];
        rv.wr0 = 1'($urandom); rv.wr1 = 1'($urandom);
        rv.a0 = 11'($urandom); rv.a1 = 11'($urandom);
        rv.wd0 = $urandom; rv.wd1 = $urandom;
        rv.be0 = $urandom; rv.be1 = $urandom;
        rv.dly = $urandom_range(0, 10);
        rv.berr = 1'($urandom);
        rv.brd = $urandom;
        txn(model(rv), $sformatf("rnd%0d", i), 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
